// File: rtl/exception_unit.sv
// Exception unit: holds ELR/ESR, counts exceptions taken, and redirects fetch
// to the handler vector on entry and back to ELR on ERET.
module exception_unit #(
  parameter int             N      = 64,
  parameter logic [N-1:0]   VECTOR = 64'hD8,
  parameter int             CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Exc,
  input  logic [3:0]       EStatus,
  input  logic             ERet,
  input  logic [N-1:0]     PC_E,
  input  logic [1:0]       rd_sel,
  output logic             ExcAck,
  output logic             PCRedirect,
  output logic [N-1:0]     PCTarget,
  output logic             InHandler,
  output logic             DoubleFault,
  output logic [N-1:0]     rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ENTER   = 2'b01,
    ST_HANDLER = 2'b10,
    ST_EXIT    = 2'b11
  } state_t;

  localparam logic [3:0]       CAUSE_NOT_INSTR = 4'b0010;
  localparam logic [CNT_W-1:0] CNT_MAX         = {CNT_W{1'b1}};

  state_t           state_r;
  state_t           state_s;
  logic             take_s;
  logic             dfault_set_s;
  logic [N-1:0]     elr_r;
  logic [3:0]       esr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             dfault_r;
  logic             exc_ack_r;
  logic             redirect_r;
  logic [N-1:0]     target_r;
  logic             in_handler_r;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and exception-take decisions
  always_comb begin
    state_s      = state_r;
    take_s       = 1'b0;
    dfault_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Exc beats a simultaneous ERet; a lone ERet is ignored here
        if (Exc) begin
          state_s = ST_ENTER;
          take_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ENTER: begin
        state_s = ST_HANDLER;
      end
      ST_HANDLER: begin
        // IRQs are masked here and stay pending upstream
        if (ERet) begin
          state_s = ST_EXIT;
        end else if (Exc && (EStatus == CAUSE_NOT_INSTR)) begin
          dfault_set_s = 1'b1;
        end else begin
          state_s = ST_HANDLER;
        end
      end
      ST_EXIT: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Exception state registers, saturating counter and sticky double fault
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elr_r    <= {N{1'b0}};
      esr_r    <= 4'b0000;
      cnt_r    <= {CNT_W{1'b0}};
      dfault_r <= 1'b0;
    end else begin
      if (take_s) begin
        elr_r <= PC_E;
        esr_r <= EStatus;
        if (cnt_r != CNT_MAX) begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end
      if (dfault_set_s) begin
        dfault_r <= 1'b1;
      end
    end
  end

  // Moore outputs registered from the next state so they align with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exc_ack_r    <= 1'b0;
      redirect_r   <= 1'b0;
      target_r     <= {N{1'b0}};
      in_handler_r <= 1'b0;
    end else begin
      exc_ack_r    <= (state_s == ST_ENTER);
      redirect_r   <= (state_s == ST_ENTER) || (state_s == ST_EXIT);
      in_handler_r <= (state_s != ST_IDLE);
      // ELR is frozen outside IDLE, so its current value is the return address
      case (state_s)
        ST_ENTER: target_r <= VECTOR;
        ST_EXIT:  target_r <= elr_r;
        default:  target_r <= {N{1'b0}};
      endcase
    end
  end

  // MRS read port
  always_comb begin
    rd_data = {N{1'b0}};
    case (rd_sel)
      2'b00:   rd_data = elr_r;
      2'b01:   rd_data = N'(esr_r);
      2'b10:   rd_data = N'(cnt_r);
      2'b11:   rd_data = N'(dfault_r);
      default: rd_data = {N{1'b0}};
    endcase
  end

  assign ExcAck      = exc_ack_r;
  assign PCRedirect  = redirect_r;
  assign PCTarget    = target_r;
  assign InHandler   = in_handler_r;
  assign DoubleFault = dfault_r;

endmodule
